// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and helpers for the multiply/divide unit
// Purpose: op codes, FSM state encoding and the counter-width helper used by
//          mul_div_unit and its sub-modules.
// Ports:   none (package).
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Ceiling log2; clog2(n+1) gives the bits needed to hold the value n.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// rtl/mdu_negate.sv - conditional two's-complement negate
// Purpose: y = neg ? -x : x. Used for operand magnitudes and result sign fix-up.
// Ports:
//   neg  in   1      negate when high
//   x    in   WIDTH  value
//   y    out  WIDTH  x or its two's complement
module mdu_negate #(
  parameter int WIDTH = 8
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? -x : x;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit with hi/lo result registers
// Purpose: MULTU/MULT by shift-add and DIVU/DIV by restoring division over a
//          2*WIDTH accumulator; one bit per cycle, then a one-cycle fix-up.
//          Optional macro MDU_SIGNED_EN: when defined, ops 01/11 are signed;
//          when undefined, op[0] is ignored and no negate logic is built.
// Ports:
//   clk    in   1      clock
//   reset  in   1      synchronous, active-high reset
//   start  in   1      request op with a/b; accepted only when busy==0
//   op     in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a      in   WIDTH  multiplicand / dividend
//   b      in   WIDTH  multiplier / divisor
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse: hi/lo hold the new result
//   dz     out  1      last divide had b==0; held until next accepted start
//   hi     out  WIDTH  product high half or remainder
//   lo     out  WIDTH  product low half or quotient
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;

  state_e           state, state_nx;
  logic [CW-1:0]    count;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] b_q;
  logic             is_div_q;

  op_e              op_in;
  logic             is_div_in;
  logic             accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [WIDTH:0]   mul_sum, div_rem, div_diff;

  assign op_in     = op_e'(op);
  assign is_div_in = (op_in == OP_DIVU) || (op_in == OP_DIV);
  assign accept    = start && ((state == IDLE) || (state == DONE));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (count == CW'(1)) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state == RUN) || (state == FIX);
    done = (state == DONE);
  end

`ifdef MDU_SIGNED_EN
  logic sgn_in, a_neg, b_neg;
  logic neg_q, neg_r;   // result negate flags: quotient/product, remainder

  assign sgn_in = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign a_neg  = sgn_in & a[WIDTH-1];
  assign b_neg  = sgn_in & b[WIDTH-1];

  // Most-negative operand negates to itself, which is its correct unsigned magnitude.
  mdu_negate #(.WIDTH(WIDTH)) u_neg_a (.neg(a_neg), .x(a), .y(a_mag));
  mdu_negate #(.WIDTH(WIDTH)) u_neg_b (.neg(b_neg), .x(b), .y(b_mag));

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;   // remainder follows the dividend's sign
    end
  end

  mdu_negate #(.WIDTH(W2))    u_neg_p (.neg(neg_q), .x(acc),               .y(prod_fix));
  mdu_negate #(.WIDTH(WIDTH)) u_neg_q (.neg(neg_q), .x(acc[WIDTH-1:0]),    .y(quo_fix));
  mdu_negate #(.WIDTH(WIDTH)) u_neg_r (.neg(neg_r), .x(acc[W2-1:WIDTH]),   .y(rem_fix));
`else
  assign a_mag    = a;
  assign b_mag    = b;
  assign prod_fix = acc;
  assign quo_fix  = acc[WIDTH-1:0];
  assign rem_fix  = acc[W2-1:WIDTH];
`endif

  // Multiply step: add multiplier into the upper half when the low bit is set, shift right.
  assign mul_sum  = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (acc[0] ? b_q : {WIDTH{1'b0}})};
  // Divide step: shift next dividend bit into the partial remainder, trial-subtract.
  assign div_rem  = {acc[W2-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_rem - {1'b0, b_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      dz       <= 1'b0;
    end else if (accept) begin
      acc      <= {{WIDTH{1'b0}}, a_mag};
      b_q      <= b_mag;
      is_div_q <= is_div_in;
      count    <= CW'(WIDTH);
      dz       <= 1'b0;
    end else if (state == RUN) begin
      count <= count - CW'(1);
      if (!is_div_q)
        acc <= {mul_sum, acc[WIDTH-1:1]};
      else if (!div_diff[WIDTH])
        acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc <= {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else if (state == FIX) begin
      if (is_div_q) begin
        // With b==0 every trial subtract succeeds, so the remainder is |a|;
        // only the quotient needs forcing to all ones.
        lo <= (b_q == '0) ? {WIDTH{1'b1}} : quo_fix;
        hi <= rem_fix;
        dz <= (b_q == '0);
      end else begin
        {hi, lo} <= prod_fix;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard testbench for mul_div_unit
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W = 8;
`ifdef MDU_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;

  task automatic check(string name, longint act, longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as the op defines them.
  function automatic exp_t model(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
    exp_t   e;
    longint xa, ya, p, q, r;
    bit     sgn;
    sgn   = SIGNED && o[0];
    xa    = sgn ? longint'($signed(x)) : longint'(x);
    ya    = sgn ? longint'($signed(y)) : longint'(y);
    e.op  = o;
    e.a   = x;
    e.b   = y;
    e.due = 0;
    if (!o[1]) begin
      p    = xa * ya;
      e.lo = p[W-1:0];
      e.hi = p[2*W-1:W];
      e.dz = 1'b0;
    end else if (y == 0) begin
      e.lo = '1;
      e.hi = x;
      e.dz = 1'b1;
    end else begin
      q    = xa / ya;
      r    = xa % ya;
      e.lo = q[W-1:0];
      e.hi = r[W-1:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y, bit noise);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL issue_wait: busy still %0d after %0d cycles, required 0", busy, n);
      return;
    end
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    e     = model(o, x, y);
    @(posedge clk);
    @(negedge clk);
    e.due = cyc + W + 1;
    sbq.push_back(e);
    if (noise) begin
      for (int i = 0; i < W - 2; i++) begin
        start = 1'($urandom_range(1));
        op    = 2'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results outstanding, required 0", sbq.size());
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: done=1 with no accepted start, required done=0");
        end else begin
          e = sbq.pop_front();
          check($sformatf("hi op=%0d a=%0h b=%0h", e.op, e.a, e.b), hi, e.hi);
          check($sformatf("lo op=%0d a=%0h b=%0h", e.op, e.a, e.b), lo, e.lo);
          check($sformatf("dz op=%0d a=%0h b=%0h", e.op, e.a, e.b), dz, e.dz);
          check("done_cycle", cyc, e.due);
          check("busy_with_done", busy, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   o;
    logic [W-1:0] x, y;
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dz", dz, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);

    // Directed cases, back to back.
    issue(OP_MULTU, 8'hC8, 8'h03, 1'b0);
    issue(OP_MULT,  8'hFD, 8'h05, 1'b0);
    issue(OP_MULT,  8'h80, 8'h80, 1'b0);
    issue(OP_DIVU,  8'h64, 8'h07, 1'b1);
    issue(OP_DIV,   8'hF9, 8'h02, 1'b1);
    issue(OP_DIVU,  8'h2A, 8'h00, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    check("dz_held", dz, 1);
    check("hi_held", hi, 8'h2A);
    check("lo_held", lo, 8'hFF);
    issue(OP_DIV,   8'h80, 8'hFF, 1'b0);
    drain();

    // Reset mid-divide discards the result and no done may follow.
    issue(OP_DIVU, 8'h64, 8'h07, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_hi", hi, 0);
    check("midreset_lo", lo, 0);
    repeat (W + 6) @(negedge clk);

    // Random operations, with boundary operands mixed in.
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom);
      x = W'($urandom);
      y = W'($urandom);
      case ($urandom_range(7))
        0: y = '0;
        1: begin x = 8'h80; y = 8'hFF; end
        2: x = 8'h80;
        default: ;
      endcase
      issue(o, x, y, 1'($urandom_range(1)));
      if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(negedge clk);
    end
    drain();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
